window3x3_linebuf: RTL
======================

# window3x3_linebuf

Streaming 3x3 neighbourhood generator. It sits directly upstream of the 3x3 morphological dilation stage in the camera-processing path. It accepts one raster-order pixel per valid cycle, buffers the previous two image rows, and presents a registered 3x3 window (p00..p22) with a qualifying strobe. The dilation stage consumes the window combinationally and needs no other context.

## Interface
- DATA_W, 10: pixel width in bits.
- IMG_W, 640: pixels per row. Must be ≥ 3.
- IMG_H, 480: rows per frame. Must be ≥ 3.
- XW, $clog2(IMG_W): column counter and win_x width.
- YW, $clog2(IMG_H): row counter and win_y width.
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pix_in  in  DATA_W  incoming pixel, raster order.
- pix_valid  in  1  pix_in is accepted this cycle. There is no backpressure.
- sof  in  1  start of frame; sampled only when pix_valid=1.
- p00..p22  out  DATA_W each  window taps, registered. pRC is row R (0 = oldest), column C (0 = leftmost).
- win_valid  out  1  window outputs form a complete in-image 3x3 window this cycle.
- win_x  out  XW  column of the window centre (p11).
- win_y  out  YW  row of the window centre (p11).
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the pixel accepted this cycle.
- Accept: an accept is a cycle with pix_valid=1. On each accept:
  - If sof=1, the pixel is taken as (0,0). Counters are forced before use, so the pixel is at row 0, col 0.
  - Otherwise the counters apply as-is.
  - After the accept, col increments. At IMG_W-1, col wraps to 0 and row increments. At (IMG_H-1, IMG_W-1), both wrap to 0.
- Line buffers: LB1 holds row-2 and LB0 holds row-1, each IMG_W deep, indexed by col.
  - On accept, read top = LB1[col] and mid = LB0[col], then write LB1[col] ← old LB0[col] and LB0[col] ← pix_in.
  - A read in the same cycle as a write to the same address returns the pre-write value.
- Window shift on accept:
  - p00 ← p01, p01 ← p02, p02 ← top
  - p10 ← p11, p11 ← p12, p12 ← mid
  - p20 ← p21, p21 ← p22, p22 ← pix_in
  - With no accept, all taps hold.
- Window qualification:
  - win_valid ← accept AND row ≥ 2 AND col ≥ 2, using the effective (post-sof) position.
  - win_x ← col-1 and win_y ← row-1, registered in the same cycle as win_valid.
  - Windows at col 0/1 straddle the previous row's right edge, and windows at rows 0/1 use stale line-buffer data. In both cases win_valid=0 and the tap values are don't-care.
- Frame completion: frame_done ← accept AND position = (IMG_H-1, IMG_W-1).
- Window count: there are exactly (IMG_W-2)*(IMG_H-2) win_valid pulses per complete frame.
- Reset:
  - col, row, all taps, win_valid, win_x, win_y and frame_done go to 0.
  - Line-buffer contents are not reset and not relied on.
- Reset mid-frame: everything restarts at (0,0). The first two rows after reset produce no windows.
- sof mid-frame: truncates the current frame with no frame_done, resynchronises to (0,0), and suppresses windows for the next two rows.
- Arithmetic: pixel data is passed through unmodified. There is no arithmetic on data and no saturation.

## Timing
- Latency: 1 clk from the accept of pixel (r,c) to the window whose p22 = pixel(r,c), p11 = pixel(r-1,c-1) and p00 = pixel(r-2,c-2), with win_valid=1.
- Strobe width: win_valid and frame_done are high for exactly one cycle per qualifying accept.
- Back-to-back accepts: supported at full rate, one pixel per clk.
- Idle cycles (pix_valid=0): outputs hold and win_valid=0. Gaps of any length, including mid-row, do not change results.
- Reset precedence: reset dominates pix_valid and sof in the same cycle, and the pixel is dropped.

## Test plan
- **Basic frame.** IMG_W=5, IMG_H=4, pixel = row*16+col, continuous valid.
  - First win_valid is 1 clk after the accept of (2,2), with p00..p22 = 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22 and win_x=1, win_y=1.
  - The frame gives 6 windows total and frame_done exactly once, 1 clk after the accept of (3,4).
- **Random stalls.** Same frame with pix_valid randomly low (about 40%). The window sequence and values are identical to the basic frame, and win_valid never asserts on an idle cycle.
- **Mid-frame sof.** Assert sof with a pixel at (2,3) of frame 1.
  - No frame_done is produced.
  - No win_valid occurs until the new frame's (2,2); its window equals the new frame's data.
- **Reset mid-frame.** Assert reset for 1 clk mid-row 2.
  - All outputs are 0 the next cycle.
  - The following frame reproduces the basic-frame results exactly.
- **Data extremes.** A frame of all 0x3FF, then a frame of all 0x000. Every valid window has all nine taps at 0x3FF (resp. 0x000). The downstream dilation output matches.
- **Two back-to-back frames.** No gap between frames. Frame 2 yields 6 windows with frame-2 data only, and 2 frame_done pulses total.

Source files
------------

// File: rtl/window3x3_linebuf_if.sv
// -----------------------------------------------------------------------------
// window3x3_linebuf_if
// Streaming pixel input and 3x3 window output bundle for window3x3_linebuf.
//   pix_in/pix_valid/sof    : raster-order pixel stream (no backpressure)
//   p00..p22                : window taps, row 0 = oldest, column 0 = leftmost
//   win_valid/win_x/win_y   : complete in-image window strobe and centre position
//   frame_done              : one-cycle pulse after the last pixel of a frame
// Modports: master drives pixels and observes windows; slave is the window
// generator itself.
// -----------------------------------------------------------------------------
interface window3x3_linebuf_if #(
    parameter int DATA_W = 10,
    parameter int XW     = 10,
    parameter int YW     = 9
);
    logic [DATA_W-1:0] pix_in;
    logic              pix_valid;
    logic              sof;

    logic [DATA_W-1:0] p00, p01, p02;
    logic [DATA_W-1:0] p10, p11, p12;
    logic [DATA_W-1:0] p20, p21, p22;
    logic              win_valid;
    logic [XW-1:0]     win_x;
    logic [YW-1:0]     win_y;
    logic              frame_done;

    modport master (
        output pix_in, pix_valid, sof,
        input  p00, p01, p02, p10, p11, p12, p20, p21, p22,
        input  win_valid, win_x, win_y, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output p00, p01, p02, p10, p11, p12, p20, p21, p22,
        output win_valid, win_x, win_y, frame_done
    );
endinterface

// File: rtl/window3x3_linebuf.sv
// -----------------------------------------------------------------------------
// window3x3_linebuf
// Streaming 3x3 neighbourhood generator. Buffers the previous two image rows
// and presents a registered 3x3 window one clock after each accepted pixel.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   s     : window3x3_linebuf_if.slave (pixel stream in, window taps out)
// Parameters: DATA_W pixel width, IMG_W / IMG_H image size (each >= 3),
//   XW / YW column and row counter widths.
// -----------------------------------------------------------------------------
module window3x3_linebuf #(
    parameter int DATA_W = 10,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int XW     = $clog2(IMG_W),
    parameter int YW     = $clog2(IMG_H)
) (
    input  logic                      clk,
    input  logic                      reset,
    window3x3_linebuf_if.slave        s
);

    // Raster position of the pixel being accepted, before sof override
    logic [XW-1:0] col;
    logic [YW-1:0] row;

    // LB1 holds row-2, LB0 holds row-1; contents are never reset
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];

    logic [XW-1:0]     col_eff;
    logic [YW-1:0]     row_eff;
    logic              col_last;
    logic              row_last;
    logic [DATA_W-1:0] top;
    logic [DATA_W-1:0] mid;

    // Window register stage
    logic [DATA_W-1:0] win_p1 [3][3];
    logic              vld_p1;
    logic [XW-1:0]     x_p1;
    logic [YW-1:0]     y_p1;
    logic              done_p1;

    // ---- stage 0: effective position and line-buffer read ----
    // sof forces the current pixel to (0,0) before any use of the counters.
    // Reads are asynchronous so a same-address write this cycle is not seen.
    always_comb begin
        col_eff  = s.sof ? '0 : col;
        row_eff  = s.sof ? '0 : row;
        col_last = (col_eff == XW'(IMG_W - 1));
        row_last = (row_eff == YW'(IMG_H - 1));
        top      = lb1[col_eff];
        mid      = lb0[col_eff];
    end

    always_ff @(posedge clk) begin
        if (s.pix_valid && !reset) begin
            lb1[col_eff] <= lb0[col_eff];
            lb0[col_eff] <= s.pix_in;
        end
    end

    // ---- stage 1: counters, window shift and qualification ----
    always_ff @(posedge clk) begin
        if (reset) begin
            col     <= '0;
            row     <= '0;
            vld_p1  <= 1'b0;
            x_p1    <= '0;
            y_p1    <= '0;
            done_p1 <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_p1[r][c] <= '0;
                end
            end
        end else begin
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            if (s.pix_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win_p1[r][0] <= win_p1[r][1];
                    win_p1[r][1] <= win_p1[r][2];
                end
                win_p1[0][2] <= top;
                win_p1[1][2] <= mid;
                win_p1[2][2] <= s.pix_in;

                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row_eff + YW'(1);
                end else begin
                    col <= col_eff + XW'(1);
                    row <= row_eff;
                end

                // Columns 0/1 straddle the previous row's right edge and rows
                // 0/1 see stale line-buffer data, so neither forms a window.
                vld_p1  <= (row_eff >= YW'(2)) && (col_eff >= XW'(2));
                x_p1    <= col_eff - XW'(1);
                y_p1    <= row_eff - YW'(1);
                done_p1 <= row_last && col_last;
            end
        end
    end

    assign s.p00        = win_p1[0][0];
    assign s.p01        = win_p1[0][1];
    assign s.p02        = win_p1[0][2];
    assign s.p10        = win_p1[1][0];
    assign s.p11        = win_p1[1][1];
    assign s.p12        = win_p1[1][2];
    assign s.p20        = win_p1[2][0];
    assign s.p21        = win_p1[2][1];
    assign s.p22        = win_p1[2][2];
    assign s.win_valid  = vld_p1;
    assign s.win_x      = x_p1;
    assign s.win_y      = y_p1;
    assign s.frame_done = done_p1;

endmodule
